// File: rtl/id_ctrl_pipe_md.sv
// id_ctrl_pipe_md
//   RV32IM ID-stage decode/control. Decodes opcode/funct3/funct7 into the
//   execute control bundle, registers it as the ID/EX control register and
//   flags unsupported encodings. RV32M multiply/divide ops are held in ID for
//   a parametrised number of cycles by a small IDLE/MD_HOLD FSM with a
//   countdown.
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   id_valid       in   instr holds a valid instruction
//   instr[31:0]    in   instruction word in ID
//   stall_in       in   downstream hazard stall: freeze FSM and ID/EX register
//   flush          in   kill the ID instruction, abort any M-op hold
//   id_stall       out  combinational: hold PC and IF/ID this cycle
//   ex_valid       out  ex_* bundle is a real instruction
//   ex_imm_sel     out  000 I/LOAD/JALR, 001 S, 010 B, 011 LUI/AUIPC, 100 JAL
//   ex_alu_op      out  R {f7[5],f7[0],f3}; I {00,f3}; branches SUB/SLT/SLTU
//   ex_branch_sel  out  01 BEQ/BGE/BGEU, 10 BNE/BLT/BLTU, 11 JAL/JALR
//   ex_use_imm     out  OP-IMM, LOAD, STORE, JALR
//   ex_mem_write   out  01 for STORE
//   ex_mem_read    out  01 for LOAD
//   ex_wb_sel      out  00 LOAD, 10 JAL/JALR, 01 otherwise
//   ex_reg_write   out  instruction writes rd
//   ex_illegal     out  issued instruction had an unsupported encoding
//   md_busy        out  FSM is in MD_HOLD
module id_ctrl_pipe_md #(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [31:0] instr,
    input  logic        stall_in,
    input  logic        flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [2:0]  ex_imm_sel,
    output logic [4:0]  ex_alu_op,
    output logic [1:0]  ex_branch_sel,
    output logic        ex_use_imm,
    output logic [1:0]  ex_mem_write,
    output logic [1:0]  ex_mem_read,
    output logic [1:0]  ex_wb_sel,
    output logic        ex_reg_write,
    output logic        ex_illegal,
    output logic        md_busy
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;

    // Countdown start value is L-1: the IDLE detection cycle is the first stall.
    localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_CYCLES > 0) ? CNT_W'(MUL_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_CYCLES > 0) ? CNT_W'(DIV_CYCLES - 1) : '0;

    typedef struct packed {
        logic       valid;
        logic [2:0] imm_sel;
        logic [4:0] alu_op;
        logic [1:0] branch_sel;
        logic       use_imm;
        logic [1:0] mem_write;
        logic [1:0] mem_read;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             unused_fields;
    ctrl_t            dec_p0;
    logic             is_mop_p0;
    logic             hold_nz;
    logic             md_start;
    logic [CNT_W-1:0] cnt_load;
    logic             fsm_stall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_p1, ctrl_d;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // ---- Stage p0: ID decode ----
    always_comb begin
        dec_p0        = '0;
        dec_p0.valid  = 1'b1;
        dec_p0.wb_sel = 2'b01;
        is_mop_p0     = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_MULDIV && ENABLE_M == 0) begin
                    dec_p0.illegal = 1'b1;
                end else begin
                    dec_p0.alu_op    = {funct7[5], funct7[0], funct3};
                    dec_p0.reg_write = 1'b1;
                    is_mop_p0        = (funct7 == F7_MULDIV);
                end
            end
            OPC_OPIMM: begin
                dec_p0.alu_op    = {2'b00, funct3};
                dec_p0.use_imm   = 1'b1;
                dec_p0.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec_p0.use_imm   = 1'b1;
                dec_p0.mem_read  = 2'b01;
                dec_p0.wb_sel    = 2'b00;
                dec_p0.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec_p0.imm_sel   = 3'b001;
                dec_p0.use_imm   = 1'b1;
                dec_p0.mem_write = 2'b01;
            end
            OPC_BRANCH: begin
                dec_p0.imm_sel = 3'b010;
                case (funct3)
                    3'b000: begin dec_p0.alu_op = ALU_SUB;  dec_p0.branch_sel = 2'b01; end
                    3'b001: begin dec_p0.alu_op = ALU_SUB;  dec_p0.branch_sel = 2'b10; end
                    3'b100: begin dec_p0.alu_op = ALU_SLT;  dec_p0.branch_sel = 2'b10; end
                    3'b101: begin dec_p0.alu_op = ALU_SLT;  dec_p0.branch_sel = 2'b01; end
                    3'b110: begin dec_p0.alu_op = ALU_SLTU; dec_p0.branch_sel = 2'b10; end
                    3'b111: begin dec_p0.alu_op = ALU_SLTU; dec_p0.branch_sel = 2'b01; end
                    default: ;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_p0.imm_sel   = 3'b011;
                dec_p0.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_p0.imm_sel    = 3'b100;
                dec_p0.branch_sel = 2'b11;
                dec_p0.wb_sel     = 2'b10;
                dec_p0.reg_write  = 1'b1;
            end
            OPC_JALR: begin
                dec_p0.branch_sel = 2'b11;
                dec_p0.use_imm    = 1'b1;
                dec_p0.wb_sel     = 2'b10;
                dec_p0.reg_write  = 1'b1;
            end
            default: dec_p0.illegal = 1'b1;
        endcase
    end

    // A zero-latency M-op class issues like any single-cycle instruction.
    assign hold_nz  = funct3[2] ? (DIV_CYCLES > 0) : (MUL_CYCLES > 0);
    assign cnt_load = funct3[2] ? DIV_LOAD : MUL_LOAD;
    assign md_start = id_valid && is_mop_p0 && hold_nz;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_p1;
        fsm_stall = 1'b0;
        case (state_q)
            S_IDLE: fsm_stall = md_start;
            S_HOLD: fsm_stall = (cnt_q != '0);
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else if (!stall_in) begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        state_d = S_HOLD;
                        cnt_d   = cnt_load;
                        ctrl_d  = '0;
                    end else begin
                        ctrl_d = id_valid ? dec_p0 : '0;
                    end
                end
                S_HOLD: begin
                    // id_valid is not consulted here: the held M-op always completes.
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - 1'b1;
                        ctrl_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        ctrl_d  = dec_p0;
                    end
                end
            endcase
        end
    end

    assign id_stall = reset_n && !flush && (stall_in || fsm_stall);

    // ---- Stage p1: ID/EX control register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_p1 <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_p1 <= ctrl_d;
        end
    end

    assign ex_valid      = ctrl_p1.valid;
    assign ex_imm_sel    = ctrl_p1.imm_sel;
    assign ex_alu_op     = ctrl_p1.alu_op;
    assign ex_branch_sel = ctrl_p1.branch_sel;
    assign ex_use_imm    = ctrl_p1.use_imm;
    assign ex_mem_write  = ctrl_p1.mem_write;
    assign ex_mem_read   = ctrl_p1.mem_read;
    assign ex_wb_sel     = ctrl_p1.wb_sel;
    assign ex_reg_write  = ctrl_p1.reg_write;
    assign ex_illegal    = ctrl_p1.illegal;
    assign md_busy       = (state_q == S_HOLD);

endmodule
